// File: rtl/monster_fire_arbiter.sv
// Purpose : shares the single monster bullet between N_MON monsters, round-robin grant with cooldown.
// Latency : eligible request seen in IDLE at edge k -> fire pulse during cycle k+1.
// Backpres: requests are level-sensitive and are only sampled in IDLE; nothing is queued while busy.
//
// Ports:
//   clk, rst (async active-low)        clock and reset
//   enable                             play-state gate; low forces IDLE and clears counters/ptr/shot count
//   level[2:0]                         0 selects COOL_L1, any other value COOL_L2 (sampled on COOL entry)
//   req[N_MON-1:0]                     per-monster fire request
//   monster_destroyed[N_MON-1:0]       destroyed monsters are never eligible
//   bullet_done                        one-cycle pulse, bullet resolved (only honoured in FLIGHT)
//   fire / fire_id[2:0]                spawn pulse and shooter index (fire_id held until next grant)
//   busy                               high in FIRE, FLIGHT and COOL
//   timeout                            one-cycle pulse when a flight is reclaimed
//   shots_fired[7:0]                   saturating count of fire pulses
module monster_fire_arbiter #(
    parameter int N_MON      = 5,
    parameter int COOL_L1    = 25_000_000,
    parameter int COOL_L2    = 12_500_000,
    parameter int FLIGHT_MAX = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       level,
    input  logic [N_MON-1:0] req,
    input  logic [N_MON-1:0] monster_destroyed,
    input  logic             bullet_done,
    output logic             fire,
    output logic [2:0]       fire_id,
    output logic             busy,
    output logic             timeout,
    output logic [7:0]       shots_fired
);

    // One-hot state encoding.
    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_FIRE   = 4'b0010;
    localparam logic [3:0] S_FLIGHT = 4'b0100;
    localparam logic [3:0] S_COOL   = 4'b1000;

    // The FIRE cycle counts as the first flight cycle, so the slot is
    // reclaimed FLIGHT_MAX cycles after the fire pulse.
    localparam logic [25:0] FLIGHT_LAST = 26'(FLIGHT_MAX - 1);

    // Cooldown counter is loaded with length-1 and counts down to 0,
    // giving exactly COOL_Lx cycles in COOL.
    localparam logic [25:0] COOL_LOAD_L1 = 26'(COOL_L1 - 1);
    localparam logic [25:0] COOL_LOAD_L2 = 26'(COOL_L2 - 1);

    localparam logic [2:0] PTR_RESET = 3'(N_MON - 1);

    logic [3:0]       state;
    logic [2:0]       ptr;
    logic [25:0]      flight_cnt;
    logic [25:0]      cool_cnt;

    logic [N_MON-1:0] eligible;
    logic             grant_vld;
    logic [2:0]       grant_id;
    logic             hi_found;
    logic             lo_found;
    logic [2:0]       hi_pick;
    logic [2:0]       lo_pick;
    logic [25:0]      cool_load;

    assign eligible  = req & ~monster_destroyed;
    assign cool_load = (level == 3'd0) ? COOL_LOAD_L1 : COOL_LOAD_L2;

    // Round-robin pick starting after ptr: the lowest eligible index above
    // ptr wins; if there is none, wrap and take the lowest eligible index
    // at or below ptr. Scanning fixed indices keeps the logic a simple
    // pair of priority encoders instead of a rotator.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = 3'd0;
        lo_pick  = 3'd0;
        for (int i = 0; i < N_MON; i++) begin
            if (eligible[i] && (3'(i) > ptr) && !hi_found) begin
                hi_found = 1'b1;
                hi_pick  = 3'(i);
            end
            if (eligible[i] && (3'(i) <= ptr) && !lo_found) begin
                lo_found = 1'b1;
                lo_pick  = 3'(i);
            end
        end
        grant_vld = hi_found | lo_found;
        grant_id  = hi_found ? hi_pick : lo_pick;
    end

    // Outputs derived purely from registered state: no input-to-output path.
    assign fire = (state == S_FIRE);
    assign busy = (state == S_FIRE) || (state == S_FLIGHT) || (state == S_COOL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ptr         <= PTR_RESET;
            fire_id     <= 3'd0;
            flight_cnt  <= 26'd0;
            cool_cnt    <= 26'd0;
            shots_fired <= 8'd0;
            timeout     <= 1'b0;
        end else if (!enable) begin
            // Leaving play: abandon any bullet and start the next round fresh
            // so the first grant on re-enable goes to monster 0.
            state       <= S_IDLE;
            ptr         <= PTR_RESET;
            flight_cnt  <= 26'd0;
            cool_cnt    <= 26'd0;
            shots_fired <= 8'd0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        state      <= S_FIRE;
                        fire_id    <= grant_id;
                        ptr        <= grant_id;
                        flight_cnt <= 26'd0;
                    end
                end

                S_FIRE: begin
                    state      <= S_FLIGHT;
                    flight_cnt <= flight_cnt + 26'd1;
                    if (shots_fired != 8'hFF) begin
                        shots_fired <= shots_fired + 8'd1;
                    end
                end

                S_FLIGHT: begin
                    // A real bullet_done beats the timeout when both land
                    // on the same cycle, so no timeout pulse is raised.
                    if (bullet_done) begin
                        state    <= S_COOL;
                        cool_cnt <= cool_load;
                    end else if (flight_cnt == FLIGHT_LAST) begin
                        state    <= S_COOL;
                        cool_cnt <= cool_load;
                        timeout  <= 1'b1;
                    end else begin
                        flight_cnt <= flight_cnt + 26'd1;
                    end
                end

                S_COOL: begin
                    if (cool_cnt == 26'd0) begin
                        state <= S_IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - 26'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monster_fire_arbiter.sv
// Directed bench for monster_fire_arbiter with small timing parameters.
// Expected shooter ids are queued when requests are driven and popped on each fire pulse.
// Outputs are sampled on the falling clock edge; inputs change on the same falling edge.
module tb_monster_fire_arbiter;

    localparam int N_MON = 5;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [2:0]       level;
    logic [N_MON-1:0] req;
    logic [N_MON-1:0] monster_destroyed;
    logic             bullet_done;
    logic             fire;
    logic [2:0]       fire_id;
    logic             busy;
    logic             timeout;
    logic [7:0]       shots_fired;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [2:0] sb[$];

    monster_fire_arbiter #(
        .N_MON      (N_MON),
        .COOL_L1    (4),
        .COOL_L2    (2),
        .FLIGHT_MAX (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .level             (level),
        .req               (req),
        .monster_destroyed (monster_destroyed),
        .bullet_done       (bullet_done),
        .fire              (fire),
        .fire_id           (fire_id),
        .busy              (busy),
        .timeout           (timeout),
        .shots_fired       (shots_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulse_done();
        bullet_done = 1'b1;
        tick();
        bullet_done = 1'b0;
    endtask

    task automatic wait_fire(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            if (fire === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) chk("fire_wait", fire, 1);
    endtask

    task automatic expect_shot(input string tag, output int at);
        logic [2:0] e;
        wait_fire(40, at);
        e = (sb.size() > 0) ? sb.pop_front() : 3'd7;
        if (at >= 0) chk(tag, fire_id, e);
    endtask

    task automatic wait_idle(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int f, prev, f2, f3, f4, at, idle_at, tcyc, npulse;
        logic saw;

        rst = 1'b0; enable = 1'b0; level = 3'd0; req = '0;
        monster_destroyed = '0; bullet_done = 1'b0;

        // Reset state.
        tick(); tick();
        chk("rst_fire", fire, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_fire_id", fire_id, 0);
        chk("rst_shots", shots_fired, 0);
        rst = 1'b1;

        // Round-robin over all five monsters, done one cycle after each FIRE.
        enable = 1'b1; level = 3'd0; req = 5'b11111;
        sb.push_back(3'd0); sb.push_back(3'd1); sb.push_back(3'd2);
        sb.push_back(3'd3); sb.push_back(3'd4); sb.push_back(3'd0);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            expect_shot("rr_id", f);
            if (k > 0) chk("rr_spacing", f - prev, 7);
            prev = f;
            tick();
            pulse_done();
        end
        chk("shots_after_6", shots_fired, 6);

        // Destroyed monsters are masked out.
        req = 5'b10101; monster_destroyed = 5'b00101;
        sb.push_back(3'd4);
        expect_shot("mask_id_a", f);
        tick(); pulse_done();
        sb.push_back(3'd4);
        expect_shot("mask_id_b", f);
        tick(); pulse_done();
        req = 5'b00101;
        wait_idle(10, idle_at);
        chk("mask_reach_idle", busy, 0);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw = saw | fire | busy;
        end
        chk("mask_no_fire", saw, 0);

        // Flight timeout, then re-grant after the cooldown.
        req = 5'b00001; monster_destroyed = '0;
        sb.push_back(3'd0);
        expect_shot("to_id", f);
        npulse = 0; tcyc = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (timeout === 1'b1) begin
                npulse++;
                tcyc = cyc;
            end
        end
        chk("to_pulses", npulse, 1);
        chk("to_delay", tcyc - f, 8);
        sb.push_back(3'd0);
        expect_shot("to_regrant_id", f2);
        chk("to_regrant_delay", f2 - f, 13);

        // Level 1 cooldown is 2 cycles.
        level = 3'd1;
        tick(); pulse_done();
        sb.push_back(3'd0);
        expect_shot("l2_id", f3);
        chk("l2_spacing", f3 - f2, 5);

        // Level change during COOL does not alter the loaded count.
        tick(); pulse_done();
        level = 3'd0;
        sb.push_back(3'd0);
        expect_shot("lvl_chg_id", f4);
        chk("lvl_chg_spacing", f4 - f3, 5);

        // Stray bullet_done in COOL and in IDLE.
        req = '0;
        tick(); pulse_done();
        pulse_done();
        wait_idle(10, idle_at);
        chk("stray_done_cool_len", idle_at - (f4 + 2), 4);
        pulse_done();
        chk("stray_done_idle_busy", busy, 0);
        chk("stray_done_idle_fire", fire, 0);

        // bullet_done on the last flight cycle: COOL without timeout.
        req = 5'b00001;
        sb.push_back(3'd0);
        expect_shot("late_done_id", f);
        for (int i = 0; i < 7; i++) tick();
        pulse_done();
        req = '0;
        chk("late_done_timeout", timeout, 0);
        chk("late_done_busy", busy, 1);
        wait_idle(10, idle_at);
        chk("late_done_idle_at", idle_at - f, 12);

        // enable dropped mid-flight.
        req = 5'b11111;
        sb.push_back(3'd1);
        expect_shot("en_pre_id", f);
        tick(); tick();
        enable = 1'b0;
        tick();
        chk("en_off_busy", busy, 0);
        chk("en_off_shots", shots_fired, 0);
        chk("en_off_fire", fire, 0);
        enable = 1'b1;
        prev = cyc;
        sb.push_back(3'd0);
        expect_shot("en_on_id", f);
        chk("req_latency", f - prev, 1);
        tick(); pulse_done();

        // Asynchronous reset in the middle of COOL.
        sb.push_back(3'd1);
        expect_shot("pre_rst_id", f);
        tick(); pulse_done();
        tick();
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_fire_id", fire_id, 0);
        chk("async_rst_shots", shots_fired, 0);
        chk("async_rst_fire", fire, 0);
        chk("async_rst_timeout", timeout, 0);
        tick();
        rst = 1'b1;

        // Shot counter saturation.
        level = 3'd1; req = 5'b11111;
        for (int k = 0; k < 300; k++) begin
            wait_fire(40, at);
            tick();
            pulse_done();
        end
        tick();
        chk("shots_saturate", shots_fired, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
